// File: rtl/div_seq_unit.sv
// div_seq_unit: iterative restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per clock.
// Optional DIV_EARLY_OUT_EN: divide-by-zero, signed overflow and |divisor|>|dividend| skip the iteration.
module div_seq_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             ready,
    output logic [WIDTH-1:0] result
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] quo, rem, dmag, a_mag, b_mag, q_fix, r_fix;
    logic [WIDTH:0] shifted, rem_trial;
    logic [CW-1:0] cnt;
    logic signed_op, a_neg, b_neg, no_borrow, rem_op, neg_q, neg_r, early;
    assign signed_op = ~op[0];
    assign a_neg = signed_op & dividend[WIDTH-1];
    assign b_neg = signed_op & divisor[WIDTH-1];
    assign a_mag = a_neg ? -dividend : dividend;
    assign b_mag = b_neg ? -divisor : divisor;
    // The true remainder can need WIDTH+1 bits after the shift; a borrow-free result always fits WIDTH.
    assign shifted = {rem, quo[WIDTH-1]};
    assign rem_trial = shifted - {1'b0, dmag};
    assign no_borrow = ~rem_trial[WIDTH];
    assign q_fix = neg_q ? -quo : quo;
    assign r_fix = neg_r ? -rem : rem;
    assign busy = state != IDLE;
`ifdef DIV_EARLY_OUT_EN
    logic div0, ovf;
    logic [WIDTH-1:0] early_quo, early_rem;
    assign div0 = divisor == '0;
    assign ovf = signed_op & (dividend == {1'b1, {(WIDTH-1){1'b0}}}) & (&divisor);
    assign early = div0 | ovf | (b_mag > a_mag);
    assign early_quo = div0 ? '1 : ovf ? a_mag : '0;
    assign early_rem = ovf ? '0 : a_mag;
`else
    assign early = 1'b0;
`endif
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: state_nx = start ? (early ? DONE : CALC) : IDLE;
            CALC: state_nx = cnt == '0 ? DONE : CALC;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state  <= IDLE;
            ready  <= 1'b0;
            result <= '0;
            quo    <= '0;
            rem    <= '0;
            dmag   <= '0;
            cnt    <= '0;
            rem_op <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
        end else begin
            state <= state_nx;
            ready <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    rem_op <= op[1];
                    // Divide by zero must keep the all-ones quotient, so it never negates.
                    neg_q  <= (a_neg ^ b_neg) & (|divisor);
                    neg_r  <= a_neg;
                    dmag   <= b_mag;
                    cnt    <= CW'(WIDTH - 1);
`ifdef DIV_EARLY_OUT_EN
                    quo    <= early ? early_quo : a_mag;
                    rem    <= early ? early_rem : '0;
`else
                    quo    <= a_mag;
                    rem    <= '0;
`endif
                end
                CALC: begin
                    rem <= no_borrow ? rem_trial[WIDTH-1:0] : shifted[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], no_borrow};
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                DONE: begin
                    result <= rem_op ? r_fix : q_fix;
                    ready  <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
